// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu engine that writes the HI/LO pair.
// Optional build macro HILO_FAST_MUL_EN: mult/multu finish after a single array-product cycle.
module hilo_muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
  logic [2*DATA_W-1:0] acc_q, acc_d;       // mul: {partial, multiplier}; div: quotient in low half
  logic [DATA_W:0]     rem_q, rem_d;
  logic                neg_q, neg_d;       // negate product / quotient
  logic                rneg_q, rneg_d;     // negate remainder
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic                accept_s, is_div_s, is_signed_s, mul_last_s, div_ok_s;
  logic [DATA_W-1:0]   a_mag_s, b_mag_s, div_quo_nx_s, quo_fin_s, rem_fin_s;
  logic [DATA_W:0]     mul_sum_s, div_shift_s, div_diff_s, div_rem_nx_s;
  logic [2*DATA_W-1:0] mul_step_s, mul_prod_s, prod_fin_s;

  assign busy   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done   = (state_q == S_FIN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

  assign is_div_s    = funct[1];
  assign is_signed_s = ~funct[0];
  assign accept_s    = start && !busy && (funct[5:2] == 4'b0110);
  assign a_mag_s     = (is_signed_s && op_a[DATA_W-1]) ? -op_a : op_a;
  assign b_mag_s     = (is_signed_s && op_b[DATA_W-1]) ? -op_b : op_b;

  // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
  assign mul_sum_s  = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                    + (acc_q[0] ? {1'b0, mcand_q} : {(DATA_W+1){1'b0}});
  assign mul_step_s = {mul_sum_s, acc_q[DATA_W-1:1]};

`ifdef HILO_FAST_MUL_EN
  assign mul_last_s = 1'b1;
  assign mul_prod_s = {{DATA_W{1'b0}}, mcand_q} * {{DATA_W{1'b0}}, acc_q[DATA_W-1:0]};
`else
  assign mul_last_s = (cnt_q == CNT_W'(DATA_W - 1));
  assign mul_prod_s = mul_step_s;
`endif

  // Restoring step: keep the trial subtraction only when it does not go negative.
  assign div_shift_s  = {rem_q[DATA_W-1:0], acc_q[DATA_W-1]};
  assign div_diff_s   = div_shift_s - {1'b0, mcand_q};
  assign div_ok_s     = ~div_diff_s[DATA_W];
  assign div_rem_nx_s = div_ok_s ? div_diff_s : div_shift_s;
  assign div_quo_nx_s = {acc_q[DATA_W-2:0], div_ok_s};

  assign prod_fin_s = neg_q  ? -mul_prod_s : mul_prod_s;
  assign quo_fin_s  = neg_q  ? -div_quo_nx_s : div_quo_nx_s;
  assign rem_fin_s  = rneg_q ? -div_rem_nx_s[DATA_W-1:0] : div_rem_nx_s[DATA_W-1:0];

  // Next-state, datapath iteration and HI/LO update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_MUL: begin
        acc_d = mul_step_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last_s) begin
          state_d = S_FIN;
          hi_d    = prod_fin_s[2*DATA_W-1:DATA_W];
          lo_d    = prod_fin_s[DATA_W-1:0];
        end else begin
          state_d = S_MUL;
        end
      end
      S_DIV: begin
        acc_d = {{DATA_W{1'b0}}, div_quo_nx_s};
        rem_d = div_rem_nx_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = S_FIN;
          hi_d    = rem_fin_s;
          lo_d    = quo_fin_s;
        end else begin
          state_d = S_DIV;
        end
      end
      S_IDLE, S_FIN: begin
        if (accept_s) begin
          cnt_d   = {CNT_W{1'b0}};
          mcand_d = is_div_s ? b_mag_s : a_mag_s;
          acc_d   = {{DATA_W{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
          rem_d   = {(DATA_W+1){1'b0}};
          neg_d   = is_signed_s && (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
          rneg_d  = is_signed_s && op_a[DATA_W-1];
          if (is_div_s && (op_b == {DATA_W{1'b0}})) begin
            state_d = S_FIN;
            hi_d    = op_a;
            lo_d    = {DATA_W{1'b1}};
          end else if (is_div_s) begin
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      mcand_q <= {DATA_W{1'b0}};
      acc_q   <= {(2*DATA_W){1'b0}};
      rem_q   <= {(DATA_W+1){1'b0}};
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= {DATA_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
